hilo_muldiv: RTL

//  Owns the HI/LO architectural registers and the iterative multiply/divide engine.
//  - Sink for the writeHILO/ALUop stream issued by decode: MULT/MULTU/DIV/DIVU, and direct MTHI/MTLO writes.
//  - Source of the HI_data/LO_data values that decode reads for MFHI/MFLO.
//  - Sits beside EX, writing HI/LO itself; raises stall_o so the pipeline holds while an op is in flight.

---
 rtl/hilo_muldiv_pkg.sv | 29 ++
 rtl/hilo_muldiv_core.sv | 72 +++++++
 rtl/hilo_muldiv.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and HILO direct-write mask bit positions.
package hilo_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_RUN   = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_e;

  localparam int HILO_HI_BIT = 1;
  localparam int HILO_LO_BIT = 0;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_core.sv
// Iterative engine: accumulator, iteration counter and one shift-add (MUL) or
// restoring shift-subtract (DIV) step per cycle on unsigned magnitudes.
module hilo_muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               fast_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               last_o
);
  import hilo_muldiv_pkg::*;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_sub;
  logic               fits;

  // For DIV, acc holds {remainder, quotient}; dividend bits feed in MSB-first from a_q.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    trial   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    fits    = (trial >= {1'b0, b_q});
    rem_sub = trial[WIDTH-1:0] - b_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      cnt_d = '0;
      acc_d = fast_i ? ({{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i}) : '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_div_i) begin
        a_d = {a_q[WIDTH-2:0], 1'b0};
        if (fits) acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
        else      acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        b_d   = {b_q[WIDTH-2:0], 1'b0};
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0} + (b_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO registers with an iterative MULT/MULTU/DIV/DIVU engine, direct MTHI/MTLO writes
// and sign fixup. Optional macro HILO_FAST_MULT_EN makes multiplies single-cycle.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] oprand1_i,
  input  logic [WIDTH-1:0] oprand2_i,
  input  logic             cancel_i,
  input  logic [1:0]       writeHILO_i,
  input  logic [WIDTH-1:0] writeHI_data_i,
  input  logic [WIDTH-1:0] writeLO_data_i,
  output logic [WIDTH-1:0] HI_data_o,
  output logic [WIDTH-1:0] LO_data_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o
);
  import hilo_muldiv_pkg::*;

  md_state_e          state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic               done_q, done_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div_zero_q, div_zero_d;

  logic               core_load, core_fast, core_step, core_last;
  logic [2*WIDTH-1:0] core_acc;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  hilo_muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (core_load),
    .fast_i   (core_fast),
    .step_i   (core_step),
    .is_div_i (is_div_q),
    .a_i      (abs_a),
    .b_i      (abs_b),
    .acc_o    (core_acc),
    .last_o   (core_last)
  );

  // Magnitudes going into the engine and the signed corrections coming out of it.
  always_comb begin
    sign_a = op_is_signed(op_i) & oprand1_i[WIDTH-1];
    sign_b = op_is_signed(op_i) & oprand2_i[WIDTH-1];
    abs_a  = sign_a ? -oprand1_i : oprand1_i;
    abs_b  = sign_b ? -oprand2_i : oprand2_i;
    prod   = neg_q ? -core_acc : core_acc;
    quo    = neg_q ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
    rem    = rem_neg_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    dividend_d = dividend_q;
    core_load  = 1'b0;
    core_fast  = 1'b0;
    core_step  = 1'b0;
    if (writeHILO_i[HILO_HI_BIT]) hi_d = writeHI_data_i;
    if (writeHILO_i[HILO_LO_BIT]) lo_d = writeLO_data_i;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i && !cancel_i) begin
          core_load  = 1'b1;
          is_div_d   = op_is_div(op_i);
          neg_d      = sign_a ^ sign_b;
          rem_neg_d  = sign_a;
          div_zero_d = (oprand2_i == '0);
          dividend_d = oprand1_i;
`ifdef HILO_FAST_MULT_EN
          if (!op_is_div(op_i)) begin
            core_fast = 1'b1;
            state_d   = MD_FIXUP;
          end else begin
            state_d   = MD_RUN;
          end
`else
          state_d    = MD_RUN;
`endif
        end
      end
      MD_RUN: begin
        if (cancel_i) begin
          state_d = MD_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) state_d = MD_FIXUP;
        end
      end
      MD_FIXUP: begin
        state_d = MD_IDLE;
        // The engine result overrides any direct write landing on the same edge.
        if (!cancel_i) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (div_zero_q) begin
            hi_d = dividend_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= MD_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      dividend_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      dividend_q <= dividend_d;
    end
  end

  assign HI_data_o = hi_q;
  assign LO_data_o = lo_q;
  assign busy_o    = (state_q != MD_IDLE);
  assign stall_o   = busy_o | (start_i & (state_q == MD_IDLE));
  assign done_o    = done_q;

endmodule
